// File: rtl/chan_sel_mux_if.sv
// chan_sel_mux_if: handshake and data bundle for the channel select mux.
//   mode      : 0 = fixed select, 1 = round-robin
//   sel       : channel index used in fixed mode
//   in_data   : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready (combinational, one-hot or zero)
//   out_data  : registered selected word
//   out_valid : registered output valid
//   out_ready : downstream ready
//   out_ch    : registered index of the channel that sourced out_data
//   sel_err   : one-cycle pulse for an out-of-range sel in fixed mode
// master drives the channel side and consumes the output; slave is the mux.
interface chan_sel_mux_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8
);
  localparam int unsigned SEL_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;

  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_ch;
  logic                    sel_err;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch, sel_err
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch, sel_err
  );
endinterface

// File: rtl/chan_sel_mux.sv
// chan_sel_mux: N-channel to 1 mux with a single-register output slot.
// Fixed mode forwards channel sel; round-robin mode grants the first valid
// channel after the last granted one. in_ready is combinational and at most
// one-hot; everything on the output side is registered.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : chan_sel_mux_if.slave (see interface header for signal list)
module chan_sel_mux #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8
) (
  input logic           clk,
  input logic           rst_n,
  chan_sel_mux_if.slave bus
);

  localparam int unsigned    SEL_W      = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;
  // Power-of-two padded channel space so every SEL_W index is in bounds.
  localparam int unsigned    PAD_W      = 1 << SEL_W;
  localparam logic [SEL_W:0] NUM_CH_EXT = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

  logic [WIDTH-1:0]  ch_data [PAD_W];
  logic [PAD_W-1:0]  valid_pad;
  logic [PAD_W-1:0]  grant_oh;

  logic              free;
  logic              sel_in_range;
  logic              rr_found;
  logic [SEL_W-1:0]  rr_idx;
  logic [SEL_W-1:0]  rr_cand;
  logic              grant_valid;
  logic [SEL_W-1:0]  grant_idx;
  logic              xfer;

  logic [SEL_W-1:0]  last_grant;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic [SEL_W-1:0]  out_ch_q;
  logic              sel_err_q;

  // Unpack channels into an indexable array; padding slots read as zero.
  for (genvar i = 0; i < PAD_W; i++) begin : g_ch
    if (i < NUM_CH) begin : g_real
      assign ch_data[i] = bus.in_data[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ch_data[i] = '0;
    end
  end

  assign valid_pad    = PAD_W'(bus.in_valid);
  assign free         = !out_valid_q || bus.out_ready;
  assign sel_in_range = {1'b0, bus.sel} < NUM_CH_EXT;

  // Round-robin search: start one past last_grant and wrap modulo NUM_CH.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      rr_cand = SEL_W'((32'(last_grant) + k) % NUM_CH);
      if (!rr_found && valid_pad[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  // Grant selection; mode and sel act within the current cycle.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = bus.sel;
    if (bus.mode) begin
      grant_valid = rr_found;
      grant_idx   = rr_idx;
    end else begin
      grant_valid = sel_in_range && valid_pad[bus.sel];
    end
  end

  // A grant only exists with the slot free and out of reset, so in_ready
  // going high implies the matching in_valid is high: that is the transfer.
  assign xfer = rst_n && free && grant_valid;

  always_comb begin
    grant_oh = '0;
    if (xfer) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  assign bus.in_ready = NUM_CH'(grant_oh);

  // Output slot, round-robin pointer and error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      sel_err_q   <= 1'b0;
      last_grant  <= LAST_CH;
    end else begin
      sel_err_q <= !bus.mode && free && !sel_in_range;
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= ch_data[grant_idx];
        out_ch_q    <= grant_idx;
        last_grant  <= grant_idx;
      end else if (free) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_chan_sel_mux.sv
// tb_chan_sel_mux: directed bench for chan_sel_mux with a 4-channel instance
// and a 3-channel instance for out-of-range select behaviour.
module tb_chan_sel_mux;

  localparam logic [31:0] DATA4 = 32'h3CA52110;
  localparam logic [23:0] DATA3 = 24'h775A33;

  logic clk = 1'b0;
  logic rst_n;
  logic rst3_n;
  int   n_pass  = 0;
  int   n_total = 0;

  logic [7:0] ch_byte [4];

  always #5 clk = ~clk;

  chan_sel_mux_if #(.NUM_CH(4), .WIDTH(8)) bus4 ();
  chan_sel_mux_if #(.NUM_CH(3), .WIDTH(8)) bus3 ();

  chan_sel_mux #(.NUM_CH(4), .WIDTH(8)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  chan_sel_mux #(.NUM_CH(3), .WIDTH(8)) u_dut3 (
    .clk   (clk),
    .rst_n (rst3_n),
    .bus   (bus3.slave)
  );

  task automatic do_reset4();
    bus4.in_valid = 4'b0000;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus4.mode      = 1'b0;
    bus4.sel       = 2'd0;
    bus4.in_data   = DATA4;
    bus4.in_valid  = 4'b1111;
    bus4.out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      n_total++; if (bus4.in_ready !== 4'b0000) $display("FAIL reset_in_ready: got %b want 0000", bus4.in_ready); else n_pass++;
      n_total++; if (bus4.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus4.out_valid); else n_pass++;
      n_total++; if (bus4.out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", bus4.out_data); else n_pass++;
      n_total++; if (bus4.out_ch !== 2'd0) $display("FAIL reset_out_ch: got %0d want 0", bus4.out_ch); else n_pass++;
      n_total++; if (bus4.sel_err !== 1'b0) $display("FAIL reset_sel_err: got %b want 0", bus4.sel_err); else n_pass++;
    end
    bus4.in_valid = 4'b0000;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++; if (bus4.out_valid !== 1'b0) $display("FAIL post_reset_idle: got %b want 0", bus4.out_valid); else n_pass++;
  endtask

  task automatic test_fixed();
    bus4.mode      = 1'b0;
    bus4.sel       = 2'd2;
    bus4.in_valid  = 4'b1111;
    bus4.out_ready = 1'b1;
    repeat (2) begin
      #1;
      n_total++; if (bus4.in_ready !== 4'b0100) $display("FAIL fixed_in_ready: got %b want 0100", bus4.in_ready); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (bus4.out_data !== 8'hA5) $display("FAIL fixed_out_data: got %h want a5", bus4.out_data); else n_pass++;
      n_total++; if (bus4.out_ch !== 2'd2) $display("FAIL fixed_out_ch: got %0d want 2", bus4.out_ch); else n_pass++;
      n_total++; if (bus4.out_valid !== 1'b1) $display("FAIL fixed_out_valid: got %b want 1", bus4.out_valid); else n_pass++;
    end
    // Selected channel idle while others are valid: no grant, slot drains.
    bus4.sel      = 2'd1;
    bus4.in_valid = 4'b1101;
    #1;
    n_total++; if (bus4.in_ready !== 4'b0000) $display("FAIL fixed_idle_in_ready: got %b want 0000", bus4.in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus4.out_valid !== 1'b0) $display("FAIL fixed_drain_valid: got %b want 0", bus4.out_valid); else n_pass++;
    n_total++; if (bus4.out_data !== 8'hA5) $display("FAIL fixed_drain_data_hold: got %h want a5", bus4.out_data); else n_pass++;
    n_total++; if (bus4.out_ch !== 2'd2) $display("FAIL fixed_drain_ch_hold: got %0d want 2", bus4.out_ch); else n_pass++;
    n_total++; if (bus4.sel_err !== 1'b0) $display("FAIL fixed_sel_err: got %b want 0", bus4.sel_err); else n_pass++;
  endtask

  task automatic test_round_robin();
    int exp_ch [9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};
    do_reset4();
    bus4.mode      = 1'b1;
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus4.in_valid = (i < 5) ? 4'b1111 : 4'b1010;
      #1;
      n_total++; if (bus4.in_ready !== 4'(1 << exp_ch[i])) $display("FAIL rr_in_ready[%0d]: got %b want %b", i, bus4.in_ready, 4'(1 << exp_ch[i])); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (bus4.out_ch !== 2'(exp_ch[i])) $display("FAIL rr_out_ch[%0d]: got %0d want %0d", i, bus4.out_ch, exp_ch[i]); else n_pass++;
      n_total++; if (bus4.out_data !== ch_byte[exp_ch[i]]) $display("FAIL rr_out_data[%0d]: got %h want %h", i, bus4.out_data, ch_byte[exp_ch[i]]); else n_pass++;
      n_total++; if (bus4.out_valid !== 1'b1) $display("FAIL rr_out_valid[%0d]: got %b want 1", i, bus4.out_valid); else n_pass++;
    end
  endtask

  // Fixed-mode transfers move the round-robin pointer; mode takes effect at once.
  task automatic test_mode_switch();
    logic [0:0] exp_mode [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0] exp_sel  [3] = '{2'd0, 2'd0, 2'd3};
    int         exp_ch   [3] = '{0, 1, 3};
    bus4.in_valid  = 4'b1111;
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus4.mode = exp_mode[i][0];
      bus4.sel  = exp_sel[i];
      #1;
      n_total++; if (bus4.in_ready !== 4'(1 << exp_ch[i])) $display("FAIL mode_in_ready[%0d]: got %b want %b", i, bus4.in_ready, 4'(1 << exp_ch[i])); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (bus4.out_ch !== 2'(exp_ch[i])) $display("FAIL mode_out_ch[%0d]: got %0d want %0d", i, bus4.out_ch, exp_ch[i]); else n_pass++;
    end
  endtask

  task automatic test_stall();
    bus4.mode      = 1'b0;
    bus4.sel       = 2'd2;
    bus4.in_valid  = 4'b1111;
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    repeat (3) begin
      #1;
      n_total++; if (bus4.in_ready !== 4'b0000) $display("FAIL stall_in_ready: got %b want 0000", bus4.in_ready); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (bus4.out_data !== 8'hA5) $display("FAIL stall_data: got %h want a5", bus4.out_data); else n_pass++;
      n_total++; if (bus4.out_ch !== 2'd2) $display("FAIL stall_ch: got %0d want 2", bus4.out_ch); else n_pass++;
      n_total++; if (bus4.out_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", bus4.out_valid); else n_pass++;
    end
    bus4.sel       = 2'd1;
    bus4.in_valid  = 4'b0010;
    bus4.out_ready = 1'b1;
    #1;
    n_total++; if (bus4.in_ready !== 4'b0010) $display("FAIL unstall_in_ready: got %b want 0010", bus4.in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus4.out_data !== 8'h21) $display("FAIL unstall_data: got %h want 21", bus4.out_data); else n_pass++;
    n_total++; if (bus4.out_ch !== 2'd1) $display("FAIL unstall_ch: got %0d want 1", bus4.out_ch); else n_pass++;
    n_total++; if (bus4.out_valid !== 1'b1) $display("FAIL unstall_valid: got %b want 1", bus4.out_valid); else n_pass++;
  endtask

  task automatic test_sel_err();
    bus3.mode      = 1'b0;
    bus3.sel       = 2'd1;
    bus3.in_data   = DATA3;
    bus3.in_valid  = 3'b111;
    bus3.out_ready = 1'b1;
    rst3_n = 1'b0;
    @(posedge clk); #1;
    rst3_n = 1'b1;
    @(posedge clk); #1;
    n_total++; if (bus3.out_data !== 8'h5A) $display("FAIL err_first_data: got %h want 5a", bus3.out_data); else n_pass++;
    bus3.sel = 2'd3;
    #1;
    n_total++; if (bus3.in_ready !== 3'b000) $display("FAIL err_in_ready: got %b want 000", bus3.in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus3.sel_err !== 1'b1) $display("FAIL err_pulse: got %b want 1", bus3.sel_err); else n_pass++;
    n_total++; if (bus3.out_valid !== 1'b0) $display("FAIL err_drain_valid: got %b want 0", bus3.out_valid); else n_pass++;
    bus3.sel = 2'd0;
    @(posedge clk); #1;
    n_total++; if (bus3.sel_err !== 1'b0) $display("FAIL err_clear: got %b want 0", bus3.sel_err); else n_pass++;
    n_total++; if (bus3.out_data !== 8'h33) $display("FAIL err_recover_data: got %h want 33", bus3.out_data); else n_pass++;
    // Out-of-range sel while stalled: slot not free, so no error.
    bus3.out_ready = 1'b0;
    bus3.sel       = 2'd3;
    @(posedge clk); #1;
    n_total++; if (bus3.sel_err !== 1'b0) $display("FAIL err_stalled: got %b want 0", bus3.sel_err); else n_pass++;
    n_total++; if (bus3.out_valid !== 1'b1) $display("FAIL err_stalled_valid: got %b want 1", bus3.out_valid); else n_pass++;
    bus3.out_ready = 1'b1;
    @(posedge clk); #1;
    n_total++; if (bus3.sel_err !== 1'b1) $display("FAIL err_after_stall: got %b want 1", bus3.sel_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset4();
    bus4.mode      = 1'b1;
    bus4.in_valid  = 4'b1111;
    bus4.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (bus4.out_ch !== 2'd1) $display("FAIL mid_stream_ch: got %0d want 1", bus4.out_ch); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus4.in_ready !== 4'b0000) $display("FAIL mid_rst_in_ready: got %b want 0000", bus4.in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus4.out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", bus4.out_valid); else n_pass++;
    n_total++; if (bus4.out_data !== 8'h00) $display("FAIL mid_rst_data: got %h want 00", bus4.out_data); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++; if (bus4.in_ready !== 4'b0001) $display("FAIL mid_rel_in_ready: got %b want 0001", bus4.in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus4.out_ch !== 2'd0) $display("FAIL mid_rel_ch: got %0d want 0", bus4.out_ch); else n_pass++;
    n_total++; if (bus4.out_data !== 8'h10) $display("FAIL mid_rel_data: got %h want 10", bus4.out_data); else n_pass++;
    // Reset during a stall drops the held word.
    bus4.out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus4.in_valid  = 4'b0000;
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    n_total++; if (bus4.out_valid !== 1'b0) $display("FAIL stall_rst_valid: got %b want 0", bus4.out_valid); else n_pass++;
  endtask

  initial begin
    ch_byte[0] = 8'h10;
    ch_byte[1] = 8'h21;
    ch_byte[2] = 8'hA5;
    ch_byte[3] = 8'h3C;
    rst3_n         = 1'b0;
    bus3.mode      = 1'b0;
    bus3.sel       = 2'd0;
    bus3.in_data   = DATA3;
    bus3.in_valid  = 3'b000;
    bus3.out_ready = 1'b1;

    test_reset();
    test_fixed();
    test_round_robin();
    test_mode_switch();
    test_stall();
    test_sel_err();
    test_reset_mid();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
